// File: rtl/prbs_checker_pkg.sv
// Shared definitions for the PRBS7 receive checker and its pattern predictor.
package prbs_checker_pkg;

    localparam int PRBS_ORDER = 7;
    // s[n] = s[n-TAP_A] ^ s[n-TAP_B]
    localparam int TAP_A      = 7;
    localparam int TAP_B      = 6;

    localparam int BIT_CNT_W  = 32;
    localparam int LOSS_CNT_W = 8;

    typedef logic [PRBS_ORDER-1:0] hist_t;
    typedef logic [1:0]            state_t;

    localparam state_t HUNT   = 2'd0;
    localparam state_t VERIFY = 2'd1;
    localparam state_t LOCKED = 2'd2;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] s;
        s = 4'd0;
        for (int i = 0; i < 8; i++) s = s + 4'(v[i]);
        return s;
    endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Received-stream and statistics bundle between the link receiver and the checker.
interface prbs_checker_if;
    logic                                   clear;
    logic                                   data_valid;
    logic [7:0]                             data_in;
    logic                                   locked;
    logic [7:0]                             error;
    logic [3:0]                             word_errors;
    logic [prbs_checker_pkg::BIT_CNT_W-1:0] bit_count;
    logic [prbs_checker_pkg::BIT_CNT_W-1:0] error_count;
    logic [prbs_checker_pkg::LOSS_CNT_W-1:0] sync_loss_count;

    modport master (
        output clear, data_valid, data_in,
        input  locked, error, word_errors, bit_count, error_count, sync_loss_count
    );

    modport slave (
        input  clear, data_valid, data_in,
        output locked, error, word_errors, bit_count, error_count, sync_loss_count
    );
endinterface

// File: rtl/prbs_checker_next8.sv
// PRBS7 eight-step lookahead: history (bit 0 newest) in, next word MSB-first and advanced history out.
module prbs7_next8
    import prbs_checker_pkg::*;
(
    input  hist_t      i_hist,
    output logic [7:0] o_word,
    output hist_t      o_hist
);

    hist_t w_h;
    logic  w_bit;

    always_comb begin
        w_h    = i_hist;
        w_bit  = 1'b0;
        o_word = '0;
        for (int i = 7; i >= 0; i--) begin
            w_bit     = w_h[TAP_A-1] ^ w_h[TAP_B-1];
            o_word[i] = w_bit;
            w_h       = {w_h[PRBS_ORDER-2:0], w_bit};
        end
        o_hist = w_h;
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS7 checker: hunts for the pattern, verifies, then counts bit errors while locked.
module prbs_checker
    import prbs_checker_pkg::*;
#(
    parameter int LOCK_WORDS = 4,
    parameter int LOSS_WORDS = 3,
    parameter int LOSS_BITS  = 3
) (
    input  logic           i_clock,
    input  logic           i_reset,
    prbs_checker_if.slave  s_if
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_WORDS);
    localparam logic [3:0] LOSS_N = 4'(LOSS_WORDS);
    localparam logic [3:0] LOSS_B = 4'(LOSS_BITS);

    state_t                r_state;
    hist_t                 r_hist;
    logic [3:0]            r_match;
    logic [3:0]            r_bad;
    logic                  r_locked;
    logic [7:0]            r_error;
    logic [3:0]            r_word_errors;
    logic [BIT_CNT_W-1:0]  r_bit_count;
    logic [BIT_CNT_W-1:0]  r_err_count;
    logic [LOSS_CNT_W-1:0] r_loss_count;

    logic [7:0]            w_pred;
    hist_t                 w_next_hist;
    logic [7:0]            w_diff;
    logic [3:0]            w_pop;
    logic                  w_bad;
    logic                  w_loss;
    logic                  w_seed_ok;
    logic [BIT_CNT_W:0]    w_err_sum;
    logic [BIT_CNT_W-1:0]  w_err_sat;

    prbs7_next8 u_pred (
        .i_hist (r_hist),
        .o_word (w_pred),
        .o_hist (w_next_hist)
    );

    assign w_diff    = s_if.data_in ^ w_pred;
    assign w_pop     = popcount8(w_diff);
    assign w_bad     = (w_pop >= LOSS_B);
    assign w_loss    = w_bad && ((r_bad + 4'd1) == LOSS_N);
    // An all-zero history is a fixed point of the LFSR and would "match" a dead link.
    assign w_seed_ok = (s_if.data_in[6:0] != 7'h00);
    assign w_err_sum = {1'b0, r_err_count} + (BIT_CNT_W+1)'(w_pop);
    assign w_err_sat = w_err_sum[BIT_CNT_W] ? '1 : w_err_sum[BIT_CNT_W-1:0];

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= HUNT;
            r_hist        <= '0;
            r_match       <= '0;
            r_bad         <= '0;
            r_locked      <= 1'b0;
            r_error       <= '0;
            r_word_errors <= '0;
            r_bit_count   <= '0;
            r_err_count   <= '0;
            r_loss_count  <= '0;
        end else begin
            if (s_if.data_valid) begin
                case (r_state)
                    HUNT: begin
                        r_error       <= '0;
                        r_word_errors <= '0;
                        r_match       <= '0;
                        if (w_seed_ok) begin
                            r_hist  <= s_if.data_in[6:0];
                            r_state <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        r_error       <= '0;
                        r_word_errors <= '0;
                        if (w_diff == 8'h00) begin
                            r_hist <= w_next_hist;
                            if ((r_match + 4'd1) == LOCK_N) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                                r_match  <= '0;
                                r_bad    <= '0;
                            end else begin
                                r_match <= r_match + 4'd1;
                            end
                        end else begin
                            r_match <= '0;
                            if (w_seed_ok) r_hist  <= s_if.data_in[6:0];
                            else           r_state <= HUNT;
                        end
                    end
                    LOCKED: begin
                        // Advance on prediction only so injected errors never leak into the predictor.
                        r_hist        <= w_next_hist;
                        r_error       <= w_diff;
                        r_word_errors <= w_pop;
                        r_bit_count   <= r_bit_count + BIT_CNT_W'(8);
                        r_err_count   <= w_err_sat;
                        r_bad         <= w_bad ? r_bad + 4'd1 : 4'd0;
                        if (w_loss) begin
                            r_state  <= HUNT;
                            r_locked <= 1'b0;
                            r_bad    <= '0;
                            if (r_loss_count != '1) r_loss_count <= r_loss_count + 1'b1;
                        end
                    end
                    default: begin
                        r_state  <= HUNT;
                        r_locked <= 1'b0;
                    end
                endcase
            end
            if (s_if.clear) begin
                r_bit_count  <= '0;
                r_err_count  <= '0;
                r_loss_count <= '0;
            end
        end
    end

    assign s_if.locked          = r_locked;
    assign s_if.error           = r_error;
    assign s_if.word_errors     = r_word_errors;
    assign s_if.bit_count       = r_bit_count;
    assign s_if.error_count     = r_err_count;
    assign s_if.sync_loss_count = r_loss_count;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, error injection, loss/relock, zero stream, clear and async reset.
module tb_prbs_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;

    prbs_checker_if dif ();

    prbs_checker #(
        .LOCK_WORDS (4),
        .LOSS_WORDS (3),
        .LOSS_BITS  (3)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .s_if    (dif)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic gb [0:4095];
    int   gp = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Next 8 bits of the reference stream (seed of seven ones, then s[n]=s[n-7]^s[n-6]).
    task automatic gen(output logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            w[i] = gb[gp];
            gp++;
        end
    endtask

    task automatic put(input logic [7:0] d, input logic clr);
        @(negedge clk);
        dif.data_valid = 1'b1;
        dif.data_in    = d;
        dif.clear      = clr;
        @(posedge clk);
        #1;
        dif.data_valid = 1'b0;
        dif.clear      = 1'b0;
    endtask

    task automatic clean(input int n);
        logic [7:0] w;
        repeat (n) begin
            gen(w);
            put(w, 1'b0);
        end
    endtask

    task automatic hit(input logic [7:0] m);
        logic [7:0] w;
        gen(w);
        put(w ^ m, 1'b0);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, ".locked"}, 32'(dif.locked), 32'd0);
        chk({tag, ".error"}, 32'(dif.error), 32'd0);
        chk({tag, ".werr"}, 32'(dif.word_errors), 32'd0);
        chk({tag, ".bits"}, dif.bit_count, 32'd0);
        chk({tag, ".errs"}, dif.error_count, 32'd0);
        chk({tag, ".loss"}, 32'(dif.sync_loss_count), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] w;
        dif.clear      = 1'b0;
        dif.data_valid = 1'b0;
        dif.data_in    = 8'h00;
        for (int n = 0; n < 4096; n++) gb[n] = (n < 7) ? 1'b1 : (gb[n-7] ^ gb[n-6]);

        repeat (3) @(posedge clk);
        #1;
        all_zero("rst");
        @(negedge clk);
        rst = 1'b0;

        // dead link never locks
        repeat (50) put(8'h00, 1'b0);
        all_zero("zero");

        // clean stream: FE, 04, ...
        clean(3);
        chk("verify.error", 32'(dif.error), 32'd0);
        clean(1);
        chk("lock.pre", 32'(dif.locked), 32'd0);
        clean(1);
        chk("lock.rise", 32'(dif.locked), 32'd1);

        clean(100);
        chk("run.bits", dif.bit_count, 32'd800);
        chk("run.errs", dif.error_count, 32'd0);

        // idle cycles with garbage must not disturb anything
        @(negedge clk);
        dif.data_in = 8'hA5;
        repeat (4) @(posedge clk);
        #1;
        chk("idle.bits", dif.bit_count, 32'd800);
        chk("idle.locked", 32'(dif.locked), 32'd1);

        // single bit error, predictor must not absorb it
        hit(8'h01);
        chk("flip.error", 32'(dif.error), 32'h01);
        chk("flip.werr", 32'(dif.word_errors), 32'd1);
        chk("flip.errs", dif.error_count, 32'd1);
        chk("flip.locked", 32'(dif.locked), 32'd1);
        clean(1);
        chk("flip.next", 32'(dif.error), 32'h00);

        // three bad words force loss of lock; last word still counted
        hit(8'h0F);
        chk("loss.w1.locked", 32'(dif.locked), 32'd1);
        chk("loss.w1.werr", 32'(dif.word_errors), 32'd4);
        hit(8'h0F);
        chk("loss.w2.locked", 32'(dif.locked), 32'd1);
        hit(8'h0F);
        chk("loss.locked", 32'(dif.locked), 32'd0);
        chk("loss.cnt", 32'(dif.sync_loss_count), 32'd1);
        chk("loss.errs", dif.error_count, 32'd13);
        chk("loss.bits", dif.bit_count, 32'd840);
        chk("loss.error", 32'(dif.error), 32'h0F);

        clean(4);
        chk("relock.pre", 32'(dif.locked), 32'd0);
        clean(1);
        chk("relock.rise", 32'(dif.locked), 32'd1);

        // bad run broken by one clean word keeps lock
        hit(8'h0F);
        hit(8'h0F);
        clean(1);
        chk("gap.clean", 32'(dif.error), 32'h00);
        hit(8'h0F);
        hit(8'h0F);
        chk("gap.locked", 32'(dif.locked), 32'd1);
        chk("gap.errs", dif.error_count, 32'd29);
        chk("gap.bits", dif.bit_count, 32'd880);
        chk("gap.loss", 32'(dif.sync_loss_count), 32'd1);

        // clear beats a simultaneous errored locked word
        clean(1);
        gen(w);
        put(w ^ 8'h01, 1'b1);
        chk("clr.bits", dif.bit_count, 32'd0);
        chk("clr.errs", dif.error_count, 32'd0);
        chk("clr.loss", 32'(dif.sync_loss_count), 32'd0);
        chk("clr.locked", 32'(dif.locked), 32'd1);
        chk("clr.error", 32'(dif.error), 32'h01);
        clean(1);
        chk("clr.after", dif.bit_count, 32'd8);

        // asynchronous reset in the middle of a valid word
        clean(3);
        gen(w);
        @(negedge clk);
        dif.data_valid = 1'b1;
        dif.data_in    = w;
        #2;
        rst = 1'b1;
        #1;
        all_zero("arst");
        @(posedge clk);
        #1;
        dif.data_valid = 1'b0;
        all_zero("arst.hold");
        @(negedge clk);
        rst = 1'b0;

        clean(4);
        chk("arst.relock.pre", 32'(dif.locked), 32'd0);
        clean(1);
        chk("arst.relock", 32'(dif.locked), 32'd1);
        chk("arst.bits", dif.bit_count, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side end of the bit-error-ratio link, opposite the LFSR pattern generator and error-injection path.
- Takes a byte-wide received stream and self-synchronises a local PRBS7 predictor to it.
- Once locked, compares every received bit against the prediction and accumulates bit, error and sync-loss statistics for readout by the test controller.

Parameters:
- LOCK_WORDS, 4: consecutive error-free words needed to declare lock (range 1..15).
- LOSS_WORDS, 3: consecutive "bad" words while locked that force loss of lock (range 1..15).
- LOSS_BITS, 3: minimum errored bits in one word for that word to count as "bad" (range 1..8).

Ports:
- clock, input, 1: single system clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- clear, input, 1: synchronous clear of bit_count, error_count and sync_loss_count. Lock state is unaffected.
- data_valid, input, 1: qualifies data_in this cycle.
- data_in, input, 8: received word. Bit 7 is the earliest bit in time.
- locked, output, 1: predictor is in the LOCKED state.
- error, output, 8: per-bit mismatch mask for the last valid word. Zero when not LOCKED.
- word_errors, output, 4: popcount of error.
- bit_count, output, 32: bits checked while LOCKED.
- error_count, output, 32: errored bits while LOCKED. Saturates at 32'hFFFFFFFF.
- sync_loss_count, output, 8: LOCKED-to-HUNT transitions. Saturates at 8'hFF.

Behaviour:
- Sequence definition: PRBS7, s[n] = s[n-7] XOR s[n-6].
  - A 7-bit history register holds the last 7 bits.
  - The predicted word is the next 8 bits, MSB first.
- Reset (async, active-high):
  - State goes to HUNT. History, match counter and bad counter are cleared.
  - All outputs are 0.
- Words with data_valid=0 are ignored. State, history and all outputs hold.
- All outputs are registered: 1-cycle latency from a valid word to error, word_errors and the counter updates.
- States:
  - HUNT: on a valid word, load history with data_in[6:0], clear match counter, go to VERIFY.
  - VERIFY: compare data_in against the prediction.
    - Mismatch: reload history from data_in[6:0] and clear match counter.
    - Match: advance history with the predicted bits and increment match counter. When it reaches LOCK_WORDS, go to LOCKED.
    - The error output stays 0 in VERIFY.
  - LOCKED:
    - History always advances with the *predicted* bits, so injected errors do not corrupt the predictor.
    - error = data_in XOR predicted. bit_count += 8. error_count += word_errors.
    - Bad-word counter: increments when word_errors >= LOSS_BITS; otherwise clears.
    - When the bad-word counter reaches LOSS_WORDS: go to HUNT, increment sync_loss_count, and deassert locked on the next edge. That final word is still counted.
- Arithmetic:
  - bit_count wraps modulo 2^32.
  - error_count saturates; the addition is done at 33 bits and clamped.
- clear and a valid LOCKED word in the same cycle: clear wins. Counters become 0, not 8 or word_errors.
- An asynchronous reset mid-word aborts everything. No partial update survives.
- An all-zero stream never locks: a zero history predicts zeros, so the block would "match" zeros.
  - Treat a loaded history of 7'h00 as invalid: stay in HUNT.

Decomposition:
- Shared package:
  - State enum {HUNT, VERIFY, LOCKED}.
  - PRBS7 tap constants.
  - Counter widths (32, 8).
- Natural sub-module: prbs7_next8.
  - Combinational: 7-bit history in, 8-bit predicted word and next 7-bit history out.
  - Reusable by the generator side.

Test Plan:
- Clean stream seeded all-ones (words 8'hFE, 8'h04, …):
  - locked rises after 1 + LOCK_WORDS valid words.
  - After 100 further locked words: bit_count = 800, error_count = 0.
- Locked stream with bit 0 flipped in one word:
  - error = 8'h01, word_errors = 1, error_count = 1, still locked.
  - The next word's error = 8'h00, confirming the predictor did not absorb the error.
- Three consecutive words XORed with 8'h0F while locked (LOSS_WORDS=3, LOSS_BITS=3):
  - locked drops, sync_loss_count = 1, error_count += 12.
  - The block relocks on the clean stream that follows.
- Two bad words, then one clean word, then two bad words:
  - Stays locked throughout.
- All-zero input for 50 words:
  - Stays in HUNT, locked = 0, all counters 0.
- clear asserted on the same cycle as a locked errored word:
  - bit_count = 0, error_count = 0, locked stays 1.
- Async reset pulse mid-stream:
  - All outputs are 0 immediately.
  - Relock requires 1 + LOCK_WORDS words.
